// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a show-ahead byte FIFO
//
// Purpose: deserializes the asynchronous rxd line into bytes and queues them
// for the core, which reads them through uart_in / uart_empty / uart_rdreq.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   rxd         serial line, asynchronous to clk, idles high
//   uart_rdreq  pop request, ignored while uart_empty is high
//   uart_in     head-of-FIFO byte, 0 while empty
//   uart_empty  FIFO holds no bytes
//   rx_count    number of bytes held, 0..2^DEPTH_LOG2
//   overrun     sticky, a received byte was dropped because the FIFO was full
//   frame_err   one-cycle pulse after a stop bit sampled low
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic                  uart_rdreq,
  output logic [7:0]            uart_in,
  output logic                  uart_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------- sync
  logic rxd_m, rxd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // ---------------------------------------------------------------- receiver
  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          push, bad_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      bit_idx   <= bit_idx_nx;
      shift     <= shift_nx;
      frame_err <= bad_stop;
    end
  end

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    push       = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          timer_nx = '0;
          state_nx = START;
        end
      end
      START: begin
        // Mid start bit: a line that is high again was only a glitch.
        if (timer == HALF_LAST) begin
          if (rxd_s) begin
            state_nx = IDLE;
          end else begin
            timer_nx   = '0;
            bit_idx_nx = '0;
            state_nx   = DATA;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timer_nx          = '0;
          shift_nx[bit_idx] = rxd_s;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      STOP: begin
        // Returning to IDLE on the sample edge leaves half a bit of margin
        // to catch an immediately following start bit.
        if (timer == BIT_LAST) begin
          timer_nx = '0;
          state_nx = IDLE;
          if (rxd_s) push = 1'b1;
          else       bad_stop = 1'b1;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                 (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign pop   = uart_rdreq && !empty;
  // A pop on the same edge frees the slot the push lands in.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overrun <= 1'b1;
    end
  end

  assign uart_empty = empty;
  assign uart_in    = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign rx_count   = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int DL2 = 2;
  localparam int DEPTH = 4;
  // push edge relative to the negedge at which the start bit is driven:
  // T0 = next edge, push = T0 + 2 + CPB/2 + 9*CPB
  localparam int PUSH_OFS = 1 + 2 + CPB / 2 + 9 * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rxd = 1'b1;
  logic         uart_rdreq = 1'b0;
  logic [7:0]   uart_in;
  logic         uart_empty;
  logic [DL2:0] rx_count;
  logic         overrun;
  logic         frame_err;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .uart_rdreq(uart_rdreq),
    .uart_in(uart_in), .uart_empty(uart_empty), .rx_count(rx_count),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct {
    int         at_cyc;
    bit         bad_stop;
    logic [7:0] data;
  } ev_t;

  ev_t        ev[$];
  logic [7:0] mq[$];
  bit         m_ov = 0;
  bit         m_fe = 0;

  always @(posedge clk) begin
    bit   pop_m, push_m, pbad;
    logic [7:0] pdata;
    cyc++;
    m_fe = 0;
    if (rst) begin
      mq.delete();
      ev.delete();
      m_ov = 0;
    end else begin
      push_m = 0; pbad = 0; pdata = 8'h00;
      pop_m = uart_rdreq && (mq.size() > 0);
      if (ev.size() > 0 && ev[0].at_cyc == cyc) begin
        push_m = 1;
        pbad   = ev[0].bad_stop;
        pdata  = ev[0].data;
        void'(ev.pop_front());
      end
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        if (pbad)                  m_fe = 1;
        else if (mq.size() < DEPTH) mq.push_back(pdata);
        else                       m_ov = 1;
      end
    end
  end

  // ------------------------------------------------------------ compare
  bit prev_empty = 1;
  int fall_cyc = -1;
  int fe_cnt = 0;

  always @(posedge clk) begin
    #2;
    chk("empty", uart_empty, mq.size() == 0);
    chk("head", uart_in, (mq.size() == 0) ? 8'h00 : mq[0]);
    chk("count", rx_count, mq.size());
    chk("overrun", overrun, m_ov);
    chk("frame_err", frame_err, m_fe);
    if (prev_empty && !uart_empty) fall_cyc = cyc;
    prev_empty = uart_empty;
    if (frame_err) fe_cnt++;
  end

  // ------------------------------------------------------------ stimulus
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_bit);
    ev_t e;
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    if (abort_bit < 0) begin
      e.at_cyc = cyc + PUSH_OFS;
      e.bad_stop = !stop_ok;
      e.data = b;
      ev.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == abort_bit) return;
      rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic pop_one();
    uart_rdreq = 1'b1;
    @(negedge clk);
    uart_rdreq = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    chk(name, uart_in, exp);
    pop_one();
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_empty", uart_empty, 1);
    chk("rst_in", uart_in, 8'h00);
    chk("rst_count", rx_count, 0);
    rst = 1'b0;
    idle(5);

    // single frame
    n = cyc;
    send_frame(8'hA5, 1, -1);
    chk("lat_lo", (fall_cyc - n >= PUSH_OFS - 1), 1);
    chk("lat_hi", (fall_cyc - n <= PUSH_OFS + 1), 1);
    chk("single_in", uart_in, 8'hA5);
    chk("single_count", rx_count, 1);
    pop_one();
    chk("single_pop_empty", uart_empty, 1);
    chk("single_pop_in", uart_in, 8'h00);
    chk("single_pop_count", rx_count, 0);
    idle(10);

    // back-to-back
    send_frame(8'h00, 1, -1);
    send_frame(8'hFF, 1, -1);
    send_frame(8'h3C, 1, -1);
    send_frame(8'h81, 1, -1);
    idle(4);
    chk("b2b_count", rx_count, 4);
    pop_expect("b2b_0", 8'h00);
    pop_expect("b2b_1", 8'hFF);
    pop_expect("b2b_2", 8'h3C);
    pop_expect("b2b_3", 8'h81);
    chk("b2b_ov", overrun, 0);
    chk("b2b_fe_cnt", fe_cnt, 0);
    idle(10);

    // pop aligned with push while full
    send_frame(8'h10, 1, -1);
    send_frame(8'h20, 1, -1);
    send_frame(8'h30, 1, -1);
    send_frame(8'h40, 1, -1);
    idle(4);
    chk("full_count", rx_count, 4);
    fork
      send_frame(8'h50, 1, -1);
      begin
        repeat (PUSH_OFS - 1) @(negedge clk);
        pop_one();
      end
    join
    chk("pp_count", rx_count, 4);
    chk("pp_ov", overrun, 0);
    pop_expect("pp_0", 8'h20);
    pop_expect("pp_1", 8'h30);
    pop_expect("pp_2", 8'h40);
    pop_expect("pp_3", 8'h50);
    idle(10);

    // overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, -1);
    idle(4);
    chk("ovr_count", rx_count, 4);
    chk("ovr_flag", overrun, 1);
    pop_expect("ovr_0", 8'h01);
    pop_expect("ovr_1", 8'h02);
    pop_expect("ovr_2", 8'h03);
    pop_expect("ovr_3", 8'h04);
    chk("ovr_sticky", overrun, 1);
    idle(10);

    // glitch: 4 low cycles, then a clean frame must still be received
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("glitch_count", rx_count, 0);
    send_frame(8'hC3, 1, -1);
    chk("post_glitch_in", uart_in, 8'hC3);
    pop_one();
    idle(10);

    // bad stop bit
    fe_cnt = 0;
    send_frame(8'h77, 0, -1);
    idle(40);
    chk("fe_pulse_len", fe_cnt, 1);
    chk("fe_count", rx_count, 0);

    // reset mid-frame with two bytes queued
    send_frame(8'h11, 1, -1);
    send_frame(8'h22, 1, -1);
    idle(4);
    chk("pre_rst_count", rx_count, 2);
    send_frame(8'h99, 1, 5);
    rst = 1'b1;
    mq.delete();
    ev.delete();
    m_ov = 0;
    #1;
    chk("mid_rst_empty", uart_empty, 1);
    chk("mid_rst_in", uart_in, 8'h00);
    chk("mid_rst_count", rx_count, 0);
    chk("mid_rst_ov", overrun, 0);
    chk("mid_rst_fe", frame_err, 0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);
    send_frame(8'h5A, 1, -1);
    chk("post_rst_in", uart_in, 8'h5A);
    chk("post_rst_count", rx_count, 1);
    pop_one();
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
